// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter
//   Shares one downstream rggen register-bus master port between REQUESTERS
//   upstream masters. Round-robin arbitration; the grant is held for the
//   whole transaction, and only one transaction is in flight downstream.
//   The winning payload is registered on the grant edge, so upstream
//   changes during BUSY cannot disturb the downstream request. The response
//   is routed combinationally to the granted requester only.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_request_*            per-requester packed request (slice i = requester i)
//   o_request_ready        per-requester response valid (one-hot or zero)
//   o_request_status       per-requester 2-bit status, OKAY for non-granted
//   o_request_read_data    downstream read data, broadcast
//   o_grant                one-hot grant, zero while idle
//   o_valid .. o_strobe    registered downstream request
//   i_ready, i_status,
//   i_read_data            downstream response

// Per-requester response steering.
module rggen_bus_arbiter_lane (
  input  logic       i_grant,
  input  logic       i_busy,
  input  logic       i_ready,
  input  logic [1:0] i_status,
  output logic       o_ready,
  output logic [1:0] o_status
);
  logic hit;
  assign hit      = i_grant && i_busy && i_ready;
  assign o_ready  = hit;
  assign o_status = hit ? i_status : 2'b00;
endmodule

module rggen_bus_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [REQUESTERS-1:0]                i_request_valid,
  input  logic [REQUESTERS-1:0]                i_request_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]  i_request_address,
  input  logic [REQUESTERS*BUS_WIDTH-1:0]      i_request_write_data,
  input  logic [REQUESTERS*BUS_WIDTH/8-1:0]    i_request_strobe,
  output logic [REQUESTERS-1:0]                o_request_ready,
  output logic [REQUESTERS*2-1:0]              o_request_status,
  output logic [BUS_WIDTH-1:0]                 o_request_read_data,
  output logic [REQUESTERS-1:0]                o_grant,
  output logic                                 o_valid,
  output logic                                 o_write,
  output logic [ADDRESS_WIDTH-1:0]             o_address,
  output logic [BUS_WIDTH-1:0]                 o_write_data,
  output logic [BUS_WIDTH/8-1:0]               o_strobe,
  input  logic                                 i_ready,
  input  logic [1:0]                           i_status,
  input  logic [BUS_WIDTH-1:0]                 i_read_data
);
  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int IDX_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                     state_q, state_d;
  logic [REQUESTERS-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic                       write_q, write_d;
  logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
  logic [BUS_WIDTH-1:0]       write_data_q, write_data_d;
  logic [STRB_W-1:0]          strobe_q, strobe_d;

  logic [REQUESTERS-1:0]      hi_mask;
  logic [REQUESTERS-1:0]      req_hi;
  logic [REQUESTERS-1:0]      req_sel;
  logic [IDX_W-1:0]           winner;
  logic                       busy;

  assign busy = (state_q == BUSY);

  // Round-robin: requests at or above the pointer take precedence; if none,
  // fall back to the full vector, which is the wrap-around case.
  assign hi_mask = ~((REQUESTERS'(1) << ptr_q) - REQUESTERS'(1));
  assign req_hi  = i_request_valid & hi_mask;
  assign req_sel = (|req_hi) ? req_hi : i_request_valid;

  always_comb begin
    winner = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (req_sel[i]) winner = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    write_d      = write_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    case (state_q)
      IDLE: begin
        if (|i_request_valid) begin
          state_d          = BUSY;
          grant_d          = '0;
          grant_d[winner]  = 1'b1;
          ptr_d            = (winner == IDX_W'(REQUESTERS - 1)) ? '0
                                                                 : winner + IDX_W'(1);
          // Payload mux keyed by the one-hot grant keeps all slices constant.
          for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_d[i]) begin
              write_d      = i_request_write[i];
              address_d    = i_request_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
              write_data_d = i_request_write_data[i*BUS_WIDTH +: BUS_WIDTH];
              strobe_d     = i_request_strobe[i*STRB_W +: STRB_W];
            end
          end
        end
      end
      BUSY: begin
        if (i_ready) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      write_q      <= write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
    end
  end

  assign o_valid             = busy;
  assign o_grant             = grant_q;
  assign o_write             = write_q;
  assign o_address           = address_q;
  assign o_write_data        = write_data_q;
  assign o_strobe            = strobe_q;
  assign o_request_read_data = i_read_data;

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_lane
    rggen_bus_arbiter_lane u_lane (
      .i_grant  (grant_q[g]),
      .i_busy   (busy),
      .i_ready  (i_ready),
      .i_status (i_status),
      .o_ready  (o_request_ready[g]),
      .o_status (o_request_status[2*g +: 2])
    );
  end
endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter: a per-cycle vector table on a
// two-requester instance, plus hand sequences for pointer wrap on a
// four-requester instance and for asynchronous reset mid-transaction.
module tb_rggen_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // two-requester instance
  logic [1:0]  a_rv, a_rw, a_rready, a_grant;
  logic [31:0] a_addr;
  logic [63:0] a_wd;
  logic [7:0]  a_strb;
  logic [3:0]  a_rstatus, a_ostrb;
  logic [31:0] a_rdata, a_wdata, a_rd;
  logic        a_valid, a_write, a_rdy;
  logic [15:0] a_address;
  logic [1:0]  a_st;

  rggen_bus_arbiter #(.REQUESTERS(2), .ADDRESS_WIDTH(16), .BUS_WIDTH(32)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_request_valid(a_rv), .i_request_write(a_rw), .i_request_address(a_addr),
    .i_request_write_data(a_wd), .i_request_strobe(a_strb),
    .o_request_ready(a_rready), .o_request_status(a_rstatus),
    .o_request_read_data(a_rdata), .o_grant(a_grant), .o_valid(a_valid),
    .o_write(a_write), .o_address(a_address), .o_write_data(a_wdata),
    .o_strobe(a_ostrb), .i_ready(a_rdy), .i_status(a_st), .i_read_data(a_rd)
  );

  // four-requester instance
  logic [3:0]   b_rv, b_rw, b_rready, b_grant, b_ostrb;
  logic [63:0]  b_addr;
  logic [127:0] b_wd;
  logic [15:0]  b_strb;
  logic [7:0]   b_rstatus;
  logic [31:0]  b_rdata, b_wdata;
  logic         b_valid, b_write, b_rdy;
  logic [15:0]  b_address;

  rggen_bus_arbiter #(.REQUESTERS(4), .ADDRESS_WIDTH(16), .BUS_WIDTH(32)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_request_valid(b_rv), .i_request_write(b_rw), .i_request_address(b_addr),
    .i_request_write_data(b_wd), .i_request_strobe(b_strb),
    .o_request_ready(b_rready), .o_request_status(b_rstatus),
    .o_request_read_data(b_rdata), .o_grant(b_grant), .o_valid(b_valid),
    .o_write(b_write), .o_address(b_address), .o_write_data(b_wdata),
    .o_strobe(b_ostrb), .i_ready(b_rdy), .i_status(2'b00), .i_read_data(32'h0)
  );

  typedef struct {
    logic [1:0]  rv, rw;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [7:0]  strb;
    logic        rdy;
    logic [1:0]  st;
    logic [31:0] rd;
    logic        ev;
    logic [1:0]  eg, er;
    logic [3:0]  es;
    logic        ew;
    logic [15:0] ea;
    logic [31:0] ewd;
    logic [3:0]  estb;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] rv, rw, input logic [31:0] addr,
                     input logic [63:0] wd, input logic [7:0] strb,
                     input logic rdy, input logic [1:0] st, input logic [31:0] rd,
                     input logic ev, input logic [1:0] eg, er, input logic [3:0] es,
                     input logic ew, input logic [15:0] ea, input logic [31:0] ewd,
                     input logic [3:0] estb);
    vec_t v;
    v.rv = rv; v.rw = rw; v.addr = addr; v.wd = wd; v.strb = strb;
    v.rdy = rdy; v.st = st; v.rd = rd; v.ev = ev; v.eg = eg; v.er = er;
    v.es = es; v.ew = ew; v.ea = ea; v.ewd = ewd; v.estb = estb;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] aw;
    logic [63:0] dw;
    a_rv = '0; a_rw = '0; a_addr = '0; a_wd = '0; a_strb = '0;
    a_rdy = 1'b0; a_st = '0; a_rd = '0;
    b_rv = '0; b_rw = '0; b_addr = '0; b_wd = '0; b_strb = '0; b_rdy = 1'b0;

    // --- reset state ---
    repeat (2) @(negedge clk);
    chk("reset_a", {a_valid, a_grant, a_rready, a_rstatus, a_write, a_address, a_wdata, a_ostrb},
        128'h0);
    chk("reset_b", {b_valid, b_grant, b_rready, b_rstatus, b_write, b_address, b_wdata, b_ostrb},
        128'h0);
    rst_n = 1'b1;

    // --- vector table (one entry per cycle) ---
    // single write from requester 1, downstream ready 3 cycles after o_valid
    aw = {16'h0010, 16'h0000}; dw = {32'hDEADBEEF, 32'h0};
    add(2'b10, 2'b10, aw, dw, 8'hF0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(2'b10, 2'b10, aw, dw, 8'hF0, 0, 0, 0, 1, 2'b10, 2'b00, 4'h0, 1, 16'h0010, 32'hDEADBEEF, 4'hF);
    add(2'b10, 2'b10, aw, dw, 8'hF0, 1, 0, 0, 1, 2'b10, 2'b10, 4'h0, 1, 16'h0010, 32'hDEADBEEF, 4'hF);
    // downstream ready while idle is ignored; read data still mirrors
    add(2'b00, 2'b00, 0, 0, 0, 1, 3, 32'hAAAA5555, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    // read from requester 0 with SLAVE_ERROR
    aw = {16'h0000, 16'h0004};
    add(2'b01, 2'b00, aw, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    add(2'b01, 2'b00, aw, 0, 0, 1, 2, 32'h12345678, 1, 2'b01, 2'b01, 4'b0010, 0, 16'h0004, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    // both requesting, zero-wait: pointer is 1 here so 1,0,1 alternate
    aw = {16'h0200, 16'h0100}; dw = {32'h000000B1, 32'h000000A0};
    add(2'b11, 2'b11, aw, dw, 8'hC3, 1, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    add(2'b11, 2'b11, aw, dw, 8'hC3, 1, 0, 0, 1, 2'b10, 2'b10, 4'h0, 1, 16'h0200, 32'hB1, 4'hC);
    add(2'b11, 2'b11, aw, dw, 8'hC3, 1, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    add(2'b11, 2'b11, aw, dw, 8'hC3, 1, 0, 0, 1, 2'b01, 2'b01, 4'h0, 1, 16'h0100, 32'hA0, 4'h3);
    add(2'b11, 2'b11, aw, dw, 8'hC3, 1, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    add(2'b11, 2'b11, aw, dw, 8'hC3, 1, 0, 0, 1, 2'b10, 2'b10, 4'h0, 1, 16'h0200, 32'hB1, 4'hC);
    // payload held while requester 0 changes its address mid-transaction
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    add(2'b01, 2'b00, 32'h00000020, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);
    add(2'b01, 2'b00, 32'h00000030, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 4'h0, 0, 16'h0020, 0, 0);
    add(2'b01, 2'b00, 32'h00000030, 0, 0, 1, 1, 0, 1, 2'b01, 2'b01, 4'b0001, 0, 16'h0020, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      a_rv = v.rv; a_rw = v.rw; a_addr = v.addr; a_wd = v.wd; a_strb = v.strb;
      a_rdy = v.rdy; a_st = v.st; a_rd = v.rd;
      #1;
      if (v.ev)
        chk($sformatf("vec%0d", i),
            {a_valid, a_grant, a_rready, a_rstatus, a_rdata, a_write, a_address, a_wdata, a_ostrb},
            {v.ev, v.eg, v.er, v.es, v.rd, v.ew, v.ea, v.ewd, v.estb});
      else
        chk($sformatf("vec%0d", i), {a_valid, a_grant, a_rready, a_rstatus, a_rdata},
            {v.ev, v.eg, v.er, v.es, v.rd});
    end

    // --- four requesters: pointer reaches 3, then wraps to 0 ---
    @(negedge clk);
    b_addr = {16'h0333, 16'h0222, 16'h0111, 16'h0000};
    b_rv = 4'b0100;
    @(negedge clk);
    chk("b_grant_2", {b_grant, b_address}, {4'b0100, 16'h0222});
    b_rdy = 1'b1; #1;
    chk("b_ready_2", b_rready, 4'b0100);
    @(negedge clk);
    b_rdy = 1'b0; b_rv = 4'b1010;
    @(negedge clk);
    chk("b_grant_3", {b_grant, b_address}, {4'b1000, 16'h0333});
    b_rdy = 1'b1; #1;
    chk("b_ready_3", b_rready, 4'b1000);
    @(negedge clk);
    b_rdy = 1'b0; #1;
    chk("b_idle_gap", {b_valid, b_grant}, 5'b0);
    @(negedge clk);
    chk("b_grant_1", {b_grant, b_address}, {4'b0010, 16'h0111});
    b_rdy = 1'b1;
    @(negedge clk);
    b_rdy = 1'b0; b_rv = 4'b0000;

    // --- async reset mid-transaction (pointer is 1 going in) ---
    @(negedge clk);
    a_rv = 2'b01; a_rw = 2'b01; a_addr = 32'h00000040; a_wd = 64'h11; a_strb = 8'h01;
    a_rdy = 1'b0; a_rd = 32'h0;
    @(negedge clk);
    chk("rst_pre_busy", {a_valid, a_grant}, 3'b101);
    a_rdy = 1'b1; #1;
    rst_n = 1'b0; #1;
    chk("rst_immediate", {a_valid, a_grant, a_rready, a_address, a_write}, 22'h0);
    a_rdy = 1'b0; a_rv = 2'b11; a_addr = 32'h00500060;
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rst_idle", {a_valid, a_grant}, 3'b000);
    @(negedge clk);
    chk("rst_ptr0_grant", {a_valid, a_grant, a_address}, {1'b1, 2'b01, 16'h0060});
    a_rdy = 1'b1; #1;
    chk("rst_ptr0_ready", a_rready, 2'b01);
    @(negedge clk);
    a_rdy = 1'b0; a_rv = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Shares one downstream rggen register-bus master port (typically feeding the AXI4-Lite or APB bridge) between REQUESTERS independent upstream masters.
- Arbitration is round-robin. The grant is locked for the whole transaction.
- The winning request payload is registered, and the response is routed back combinationally to the granted requester only.
- Exactly one transaction is outstanding downstream at any time.

Parameters:
- REQUESTERS, 2, number of upstream requesters (≥2).
- ADDRESS_WIDTH, 16, bus address width.
- BUS_WIDTH, 32, data width. Strobe width is BUS_WIDTH/8.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_request_valid  input  REQUESTERS  per-requester request valid.
- i_request_write  input  REQUESTERS  per-requester access type: 1 = write, 0 = read.
- i_request_address  input  REQUESTERS*ADDRESS_WIDTH  packed addresses; requester i occupies slice i.
- i_request_write_data  input  REQUESTERS*BUS_WIDTH  packed write data.
- i_request_strobe  input  REQUESTERS*BUS_WIDTH/8  packed byte strobes.
- o_request_ready  output  REQUESTERS  per-requester response valid; at most one bit set.
- o_request_status  output  REQUESTERS*2  per-requester response status (rggen_status encoding).
- o_request_read_data  output  BUS_WIDTH  read data, broadcast to all requesters.
- o_grant  output  REQUESTERS  one-hot current grant; zero when idle.
- o_valid  output  1  downstream request valid.
- o_write  output  1  downstream access type.
- o_address  output  ADDRESS_WIDTH  downstream address.
- o_write_data  output  BUS_WIDTH  downstream write data.
- o_strobe  output  BUS_WIDTH/8  downstream byte strobes.
- i_ready  input  1  downstream response valid.
- i_status  input  2  downstream status: 0 OKAY, 1 EXOKAY, 2 SLAVE_ERROR, 3 DECODE_ERROR.
- i_read_data  input  BUS_WIDTH  downstream read data.

Behaviour:
- Reset values: state IDLE, grant 0, priority pointer 0.
  - o_valid 0; o_write, o_address, o_write_data, o_strobe all 0.
  - o_request_ready 0, o_grant 0.
- Upstream protocol: a requester holds valid and its payload stable until it sees its ready bit. It then may drop valid or present a new request on the next cycle.
- FSM IDLE:
  - If any i_request_valid bit is set, select the first set bit searching from the pointer upward, with wrap-around modulo REQUESTERS.
  - On that edge: latch a one-hot grant, latch the winner's write/address/write_data/strobe into the output registers, set pointer = (winner+1) mod REQUESTERS, go to BUSY.
  - If no bit is set: stay in IDLE; pointer is unchanged.
- FSM BUSY:
  - o_valid=1 and the registered payload is driven. The payload is independent of the upstream inputs, so a protocol-violating requester that changes inputs does not alter the downstream request.
  - Cycles with i_ready=0: hold everything.
  - Cycle with i_ready=1 (combinational routing, same cycle):
    - o_request_ready[g]=1 for the granted requester g.
    - o_request_status slice g = i_status.
    - o_request_read_data = i_read_data.
  - On that edge: go to IDLE, clear grant, o_valid=0. Payload registers may hold their last value.
- Non-granted status slices are 0 (OKAY). o_request_read_data always mirrors i_read_data.
- i_ready while IDLE is ignored: no upstream ready is produced.
- Latency: request valid at cycle t → o_valid at t+1.
  - Earliest upstream ready is at t+1 (downstream zero-wait).
  - Minimum spacing between downstream transactions is 2 cycles (one IDLE bubble).
- Requests arriving while BUSY wait. There is no starvation: with all requesters continuously requesting, each requester is served once per REQUESTERS transactions.
- Asynchronous reset mid-transaction:
  - All outputs return to reset values immediately; pointer returns to 0.
  - The downstream transaction is abandoned, and the downstream is reset in the same domain.

Test Plan:
- Single requester 1 write addr 0x0010 data 0xDEADBEEF strobe 0xF, downstream ready 3 cycles after o_valid with status 0 → o_valid asserted cycle t+1 with exactly that payload; o_request_ready=2'b10 for one cycle; o_grant=2'b10 during BUSY.
- Requesters 0 and 1 both valid continuously, zero-wait downstream → grants alternate 0,1,0,1; o_valid pulses every 2 cycles; each requester receives one ready per 4 cycles.
- Read from requester 0 at 0x0004, downstream returns i_read_data 0x12345678, i_status 2 → requester 0 sees ready, status 2 and data 0x12345678; requester 1 slice status 0 and ready 0.
- REQUESTERS=4, pointer at 3, requests on 1 and 3 → 3 granted first, pointer wraps to 0, then 1 granted.
- Requester 0 changes its address from 0x0020 to 0x0030 while BUSY → o_address stays 0x0020 until ready.
- Assert i_rst_n=0 while BUSY with i_ready=0 → o_valid, o_grant and o_request_ready all 0 immediately; after release a pending request on requester 1 with requester 0 also valid grants requester 0 first (pointer reset to 0).
